// File: rtl/tt_sweep.sv
// Truth-table sweeper: walks all 2^N_IN input vectors, evaluates N_FN LUT functions and counts true minterms.
// Define GRAY_ORDER_EN to visit vectors in Gray order instead of ascending binary order.
module tt_sweep #(
    parameter int N_IN     = 3,
    parameter int N_FN     = 1,
    parameter int STEP_CYC = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       hold,
    input  logic [N_FN*(2**N_IN)-1:0]  lut,
    output logic [N_IN-1:0]            abc,
    output logic [N_FN-1:0]            f,
    output logic                       valid,
    output logic                       busy,
    output logic                       done,
    output logic [N_FN*(N_IN+1)-1:0]   ones_cnt
);

    localparam int N_VEC = 2**N_IN;
    localparam int LUT_W = N_FN*N_VEC;
    localparam int DW    = $clog2(STEP_CYC+1);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(STEP_CYC-1);
    localparam logic [N_IN-1:0] IDX_LAST   = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    r_state, w_state_next;
    logic [N_IN-1:0]           r_idx;
    logic [DW-1:0]             r_dwell;
    logic [LUT_W-1:0]          r_lut;
    logic [N_FN-1:0]           r_f;
    logic [N_FN-1:0][N_IN:0]   r_cnt;

    logic                      w_start;
    logic                      w_last;
    logic [N_IN-1:0]           w_idx_next;
    logic [N_IN-1:0]           w_abc_next;
    logic [LUT_W-1:0]          w_lut_src;
    logic [N_FN-1:0]           w_f_next;

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign valid  = busy && (r_dwell == DWELL_LAST) && !hold;
    assign w_start = (r_state == S_IDLE) && start;
    assign w_last  = (r_idx == IDX_LAST);

`ifdef GRAY_ORDER_EN
    assign abc        = r_idx ^ (r_idx >> 1);
    assign w_abc_next = w_idx_next ^ (w_idx_next >> 1);
`else
    assign abc        = r_idx;
    assign w_abc_next = w_idx_next;
`endif

    assign w_idx_next = w_start ? '0 : r_idx + N_IN'(1);
    // The first vector is looked up in the live lut, since the copy is captured on the same edge.
    assign w_lut_src  = w_start ? lut : r_lut;
    assign f          = r_f;
    assign ones_cnt   = r_cnt;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        w_f_next = '0;
        for (int j = 0; j < N_FN; j++)
            w_f_next[j] = w_lut_src[j*N_VEC + int'(w_abc_next)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (valid && w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_dwell <= '0;
            r_lut   <= '0;
            r_f     <= '0;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_lut   <= lut;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dwell <= '0;
            r_f     <= w_f_next;
        end else if (valid) begin
            for (int j = 0; j < N_FN; j++)
                r_cnt[j] <= r_cnt[j] + {{N_IN{1'b0}}, r_f[j]};
            r_dwell <= '0;
            // After the last sample abc/f stay put so IDLE shows the final vector.
            if (!w_last) begin
                r_idx <= w_idx_next;
                r_f   <= w_f_next;
            end
        end else if (busy && !hold) begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

endmodule

// File: tb/tb_tt_sweep.sv
// Self-checking bench for tt_sweep: a per-cycle behavioural model plus literal checks of the reference sweeps.
module tb_tt_sweep;

    localparam int N_IN     = 3;
    localparam int N_FN     = 2;
    localparam int STEP_CYC = 10;
    localparam int N_VEC    = 2**N_IN;
    localparam int LUT_W    = N_FN*N_VEC;
    localparam int CNT_W    = N_FN*(N_IN+1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              hold = 1'b0;
    logic [LUT_W-1:0]  lut = '0;
    logic [N_IN-1:0]   abc;
    logic [N_FN-1:0]   f;
    logic              valid, busy, done;
    logic [CNT_W-1:0]  ones_cnt;

    tt_sweep #(.N_IN(N_IN), .N_FN(N_FN), .STEP_CYC(STEP_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .lut(lut),
        .abc(abc), .f(f), .valid(valid), .busy(busy), .done(done), .ones_cnt(ones_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: vector order, function lookup and per-function counts from first principles.
    function automatic logic [N_IN-1:0] order(input int k);
`ifdef GRAY_ORDER_EN
        return N_IN'(k ^ (k >> 1));
`else
        return N_IN'(k);
`endif
    endfunction

    function automatic logic [N_FN-1:0] f_of(input logic [LUT_W-1:0] l, input logic [N_IN-1:0] a);
        logic [N_FN-1:0] r;
        for (int j = 0; j < N_FN; j++) r[j] = l[j*N_VEC + int'(a)];
        return r;
    endfunction

    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t          m_state = M_IDLE;
    logic [LUT_W-1:0] m_lut = '0;
    int               m_cnt [N_FN];
    int               m_k, m_active, m_cyc, m_busy_seen, m_done_at;
    int               m_sweeps = 0;
    logic [N_IN-1:0]  m_idle_abc = '0;
    logic [N_FN-1:0]  m_idle_f = '0;
    logic [N_IN-1:0]  cap_abc [N_VEC];
    logic [N_FN-1:0]  cap_f   [N_VEC];
    logic             exp_valid;

    function automatic logic [CNT_W-1:0] cnt_vec();
        logic [CNT_W-1:0] v;
        v = '0;
        for (int j = 0; j < N_FN; j++) v[j*(N_IN+1) +: N_IN+1] = (N_IN+1)'(m_cnt[j]);
        return v;
    endfunction

    initial for (int j = 0; j < N_FN; j++) m_cnt[j] = 0;

    // Compare process: outputs are stable at the falling edge; inputs change just after rising edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_state = M_IDLE;
            for (int j = 0; j < N_FN; j++) m_cnt[j] = 0;
            m_idle_abc = '0;
            m_idle_f   = '0;
            check("reset_outputs", {abc, f, valid, busy, done, ones_cnt}, '0);
        end else begin
            case (m_state)
                M_IDLE: begin
                    check("idle_ctrl", {valid, busy, done}, 3'b000);
                    check("idle_abc", abc, m_idle_abc);
                    check("idle_f", f, m_idle_f);
                    check("idle_cnt", ones_cnt, cnt_vec());
                    if (start) begin
                        m_state = M_RUN;
                        m_lut = lut;
                        for (int j = 0; j < N_FN; j++) m_cnt[j] = 0;
                        m_k = 0; m_active = 0; m_cyc = 0; m_busy_seen = 0;
                    end
                end
                M_RUN: begin
                    m_cyc++;
                    if (busy) m_busy_seen++;
                    exp_valid = !hold && (m_active % STEP_CYC == STEP_CYC-1);
                    check("run_ctrl", {busy, done}, 2'b10);
                    check("run_valid", valid, exp_valid);
                    check("run_abc", abc, order(m_k));
                    check("run_f", f, f_of(m_lut, order(m_k)));
                    check("run_cnt", ones_cnt, cnt_vec());
                    if (!hold) m_active++;
                    if (exp_valid) begin
                        cap_abc[m_k] = abc;
                        cap_f[m_k]   = f;
                        for (int j = 0; j < N_FN; j++) m_cnt[j] += int'(f_of(m_lut, order(m_k))[j]);
                        m_k++;
                        if (m_k == N_VEC) m_state = M_DONE;
                    end
                end
                M_DONE: begin
                    m_cyc++;
                    check("done_ctrl", {valid, busy, done}, 3'b001);
                    check("done_cnt", ones_cnt, cnt_vec());
                    m_done_at  = m_cyc;
                    m_idle_abc = order(N_VEC-1);
                    m_idle_f   = f_of(m_lut, order(N_VEC-1));
                    m_sweeps++;
                    m_state = M_IDLE;
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    task automatic do_start(input logic [LUT_W-1:0] l);
        @(posedge clk); #1;
        lut = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_sweep(input int budget, input int s0);
        int n;
        n = 0;
        while (m_sweeps == s0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_sweeps == s0) check("sweep_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_abc(input logic [N_IN-1:0] a, input int budget);
        int n;
        n = 0;
        while (abc !== a && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (abc !== a) check("abc_wait_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_random(input int budget);
        int s0, n;
        s0 = m_sweeps;
        do_start(LUT_W'($urandom));
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (m_sweeps != s0 || n >= budget) break;
            hold = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) lut = LUT_W'($urandom);
            n++;
        end
        hold = 1'b0; start = 1'b0;
        if (m_sweeps == s0) check("random_timeout", 64'd0, 64'd1);
    endtask

    logic [N_IN-1:0] lit_abc [N_VEC];
    logic            lit_f0  [N_VEC];
    int              s0;

    initial begin
`ifdef GRAY_ORDER_EN
        lit_abc = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        lit_f0  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        lit_abc = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        lit_f0  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reference run: fn0 = 8'hBB, fn1 = constant 1.
        s0 = m_sweeps;
        do_start({8'hFF, 8'hBB});
        check("start_abc0", abc, 3'd0);
        wait_sweep(200, s0);
        for (int k = 0; k < N_VEC; k++) begin
            check("ref_abc_lit", cap_abc[k], lit_abc[k]);
            check("ref_f0_lit", cap_f[k][0], lit_f0[k]);
        end
        check("ref_cnt_fn0", ones_cnt[0 +: 4], 4'd6);
        check("ref_cnt_fn1", ones_cnt[4 +: 4], 4'd8);
        check("ref_busy_len", m_busy_seen, 80);
        check("ref_done_at", m_done_at, 81);
        repeat (3) @(posedge clk);

        // Hold for 5 cycles while abc=3.
        s0 = m_sweeps;
        do_start({8'hFF, 8'hBB});
        wait_abc(3'd3, 100);
        hold = 1'b1;
        repeat (5) @(posedge clk);
        #1 hold = 1'b0;
        wait_sweep(200, s0);
        check("hold_busy_len", m_busy_seen, 85);
        check("hold_cnt_fn0", ones_cnt[0 +: 4], 4'd6);

        // start and lut changes during RUN are ignored.
        s0 = m_sweeps;
        do_start({8'hFF, 8'hBB});
        repeat (15) @(posedge clk);
        #1 start = 1'b1; lut = '0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_sweep(200, s0);
        check("ignore_cnt_fn0", ones_cnt[0 +: 4], 4'd6);
        check("ignore_no_restart", m_sweeps - s0, 1);
        repeat (4) @(posedge clk);
        check("ignore_idle_busy", busy, 1'b0);

        // Multi-function: fn1 always 1, fn0 always 0.
        s0 = m_sweeps;
        do_start({8'hFF, 8'h00});
        repeat (12) @(posedge clk);
        check("multi_f_lit", f, 2'b10);
        wait_sweep(200, s0);
        check("multi_cnt_fn0", ones_cnt[0 +: 4], 4'd0);
        check("multi_cnt_fn1", ones_cnt[4 +: 4], 4'd8);

        // Reset mid-RUN at vector index 4, then a clean restart.
        do_start({8'hFF, 8'hBB});
        wait_abc(order(4), 100);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {abc, f, valid, busy, done, ones_cnt}, '0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        s0 = m_sweeps;
        do_start({8'hFF, 8'hBB});
        check("restart_abc0", abc, 3'd0);
        wait_sweep(200, s0);
        check("restart_cnt_fn0", ones_cnt[0 +: 4], 4'd6);

        // Randomized sweeps with random hold, start and lut activity.
        for (int r = 0; r < 8; r++) begin
            run_random(400);
            repeat ($urandom_range(1, 4)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_sweep.md
Name: tt_sweep

Overview:
- Sequential truth-table sweeper: steps an N_IN-bit input vector through all 2^N_IN combinations and evaluates N_FN programmable Boolean functions, each stored as a minterm mask (LUT).
- Emits one result sample per vector and a per-function count of true minterms.
- Replaces hand-written combinational function blocks and their for-loop stimulus benches with one reusable, self-timed block for lab and exercise designs.

Parameters:
- N_IN, 3, input vector width (1..8); input bit order is {a,b,c,...}, MSB first.
- N_FN, 1, number of functions evaluated in parallel (1..8).
- STEP_CYC, 10, clock cycles each vector is held (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; sampled only in IDLE.
- hold  in  1  pause; freezes dwell counter and suppresses valid.
- lut  in  N_FN*2^N_IN  function j, minterm k at bit j*2^N_IN+k.
- abc  out  N_IN  current input vector.
- f  out  N_FN  f[j] = latched lut bit for function j at index abc.
- valid  out  1  sample strobe for the current abc/f.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of sweep.
- ones_cnt  out  N_FN*(N_IN+1)  per-function count of minterms with f=1, field j at [j*(N_IN+1) +: N_IN+1].

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE; abc, f, valid, busy, done, ones_cnt and internal lut copy all 0; dwell counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 does all of the following:
  - latches lut internally;
  - clears ones_cnt;
  - sets abc=0, f=lut[0], dwell=0, busy=1;
  - moves to RUN.
  - With start=0, IDLE holds abc, f and ones_cnt from the last sweep.
- RUN:
  - valid = RUN && dwell==STEP_CYC-1 && !hold (combinational decode of registers and hold).
  - At an edge with valid=1: ones_cnt[j] += f[j] for every j; dwell=0.
    - If index < 2^N_IN-1: the index increments, and abc/f update at that same edge.
    - If the last index was sampled: go to DONE.
  - Otherwise, with hold=0: dwell increments.
  - With hold=1: dwell, abc and f are frozen.
- DONE: exactly one cycle. done=1, busy=0, valid=0, then IDLE.
- Timing: with hold=0, busy is high for exactly 2^N_IN*STEP_CYC cycles after E0, and done is high in the following cycle.
- start is ignored in RUN and DONE. A lut change during RUN has no effect, because the latched copy is used.
- Arithmetic: ones_cnt fields are N_IN+1 bits wide, so 2^N_IN cannot overflow. Dwell counter width is $clog2(STEP_CYC+1).
- f is registered and always consistent with abc in the same cycle.
- Reset mid-RUN aborts immediately. No done pulse is produced, and the partial ones_cnt is cleared.

Optional Feature:
- Macro GRAY_ORDER_EN.
- Defined: abc = idx ^ (idx>>1), i.e. Gray order, and f uses the lut bit at that abc. Consecutive vectors differ by one bit. Final ones_cnt is identical to binary order.
- Undefined: abc = idx, i.e. ascending binary order.

Test Plan:
- Reset: assert rst_n=0 mid-RUN at vector 4 -> abc, f, valid, busy, done, ones_cnt all 0 before the next edge; FSM in IDLE; a subsequent start runs from abc=0.
- Reference function f1=~a~b|bc|a~b, lut=8'hBB, STEP_CYC=10, pulse start -> 8 valid pulses 10 cycles apart with abc=0..7 and f=1,1,0,1,1,1,0,1; ones_cnt=6; busy high 80 cycles; done one cycle at cycle 81.
- Hold: same as the reference-function run, with hold=1 for 5 cycles during abc=3 -> no valid while held; abc/f frozen; busy high 85 cycles; ones_cnt=6.
- Ignored inputs: start pulsed again and lut changed to 8'h00 during RUN -> sweep unaffected; ones_cnt=6; no restart.
- Multi-function: N_FN=2, lut={8'hFF,8'h00} -> f=2'b10 at every vector; ones_cnt fields: fn0=0, fn1=8.
- GRAY_ORDER_EN defined, lut=8'hBB -> abc=0,1,3,2,6,7,5,4; f=1,1,1,0,0,1,1,1; ones_cnt=6.
